// File: rtl/sipo_frame_receiver_if.sv
// Serial link bundle between a framed serial transmitter and the SIPO receiver.
//   ser_en    : bit strobe, line is sampled only when high
//   ser_in    : serial data line, idles high
//   q         : last correctly framed N-bit word
//   valid     : one-cycle pulse, q was updated
//   frame_err : one-cycle pulse, stop bit was 0 and the word was dropped
//   busy      : receiver is inside a frame (DATA or STOP)
// master = line driver / word consumer side, slave = receiver side.
interface sipo_frame_receiver_if #(
    parameter int N = 8
);
    logic         ser_en;
    logic         ser_in;
    logic [N-1:0] q;
    logic         valid;
    logic         frame_err;
    logic         busy;

    modport master (
        output ser_en,
        output ser_in,
        input  q,
        input  valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  ser_en,
        input  ser_in,
        output q,
        output valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/sipo_frame_receiver.sv
// Serial-in parallel-out frame receiver.
// Frame: start bit (0), N data bits LSB first, stop bit (1); line idles high.
// Each good frame is presented on q with a one-cycle valid pulse; a frame whose
// stop bit is 0 is discarded with a one-cycle frame_err pulse.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   rx  : slave side of sipo_frame_receiver_if (ser_en, ser_in in;
//         q, valid, frame_err, busy out)
module sipo_frame_receiver #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sipo_frame_receiver_if.slave rx
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  shreg;
    logic [N-1:0]  q_r;
    logic          valid_r;
    logic          frame_err_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            q_r         <= '0;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            // Status strobes are single-cycle; they only rise on a stop-bit edge.
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            if (rx.ser_en) begin
                case (state)
                    IDLE: begin
                        if (!rx.ser_in) begin
                            state <= DATA;
                            cnt   <= '0;
                        end
                    end
                    DATA: begin
                        // LSB arrives first, so new bits enter at the top and
                        // walk down; after N shifts bit 0 sits in shreg[0].
                        shreg <= {rx.ser_in, shreg[N-1:1]};
                        if (cnt == CW'(N - 1)) begin
                            state <= STOP;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        // A bad stop bit is not reinterpreted as a start bit.
                        state <= IDLE;
                        if (rx.ser_in) begin
                            q_r     <= shreg;
                            valid_r <= 1'b1;
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign rx.q         = q_r;
    assign rx.valid     = valid_r;
    assign rx.frame_err = frame_err_r;
    assign rx.busy      = (state == DATA) || (state == STOP);

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Directed testbench for sipo_frame_receiver (N = 8).
module tb_sipo_frame_receiver;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sipo_frame_receiver_if #(.N(N)) bus ();

    sipo_frame_receiver #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus.slave)
    );

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int vld_pulses = 0;

    always @(posedge clk) cyc = cyc + 1;
    always @(negedge clk) if (bus.valid === 1'b1) vld_pulses = vld_pulses + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic en, input logic b);
        @(negedge clk);
        bus.ser_en = en;
        bus.ser_in = b;
        @(posedge clk);
        #1;
    endtask

    // Sends start, 8 data bits LSB first, stop. With gaps, each enabled
    // edge is followed by a disabled edge holding the same line level.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit gaps,
                              input string tag, output int stop_cyc);
        step(1'b1, 1'b0);
        check({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
        if (gaps) begin
            step(1'b0, 1'b0);
            check({tag, "_busy_gap"}, 32'(bus.busy), 32'd1);
        end
        for (int i = 0; i < N; i++) begin
            step(1'b1, d[i]);
            check({tag, "_busy_data"}, 32'(bus.busy), 32'd1);
            check({tag, "_valid_data"}, 32'(bus.valid), 32'd0);
            if (gaps) begin
                step(1'b0, d[i]);
                check({tag, "_busy_gap"}, 32'(bus.busy), 32'd1);
            end
        end
        step(1'b1, stop_bit);
        stop_cyc = cyc;
    endtask

    int c1, c2, c3, c4, v0;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        bus.ser_en = 1'b0;
        bus.ser_in = 1'b1;
        #2;
        check("rst_q", 32'(bus.q), 32'h0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_ferr", 32'(bus.frame_err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Test 1: single frame 0xB4
        send_frame(8'hB4, 1'b1, 1'b0, "t1", c1);
        check("t1_valid", 32'(bus.valid), 32'd1);
        check("t1_q", 32'(bus.q), 32'hB4);
        check("t1_ferr", 32'(bus.frame_err), 32'd0);
        check("t1_busy_end", 32'(bus.busy), 32'd0);
        step(1'b1, 1'b1);
        check("t1_valid_drop", 32'(bus.valid), 32'd0);
        check("t1_q_hold", 32'(bus.q), 32'hB4);

        // Test 2: back-to-back 0xB4 then 0xAF with no idle gap
        send_frame(8'hB4, 1'b1, 1'b0, "t2a", c1);
        check("t2a_valid", 32'(bus.valid), 32'd1);
        check("t2a_q", 32'(bus.q), 32'hB4);
        send_frame(8'hAF, 1'b1, 1'b0, "t2b", c2);
        check("t2b_valid", 32'(bus.valid), 32'd1);
        check("t2b_q", 32'(bus.q), 32'hAF);
        check("t2_spacing", 32'(c2 - c1), 32'd10);
        step(1'b1, 1'b1);
        check("t2_valid_drop", 32'(bus.valid), 32'd0);

        // Test 3: 0x3C with bad stop bit
        v0 = vld_pulses;
        send_frame(8'h3C, 1'b0, 1'b0, "t3", c3);
        check("t3_ferr", 32'(bus.frame_err), 32'd1);
        check("t3_valid", 32'(bus.valid), 32'd0);
        check("t3_q_kept", 32'(bus.q), 32'hAF);
        check("t3_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            check("t3_idle_busy", 32'(bus.busy), 32'd0);
            check("t3_idle_ferr", 32'(bus.frame_err), 32'd0);
        end
        check("t3_no_valid", 32'(vld_pulses - v0), 32'd0);

        // Test 4: 0xA5 with ser_en toggling
        v0 = vld_pulses;
        send_frame(8'hA5, 1'b1, 1'b1, "t4", c4);
        check("t4_valid", 32'(bus.valid), 32'd1);
        check("t4_q", 32'(bus.q), 32'hA5);
        step(1'b0, 1'b1);
        check("t4_valid_drop", 32'(bus.valid), 32'd0);
        check("t4_busy_end", 32'(bus.busy), 32'd0);
        step(1'b1, 1'b1);
        check("t4_one_pulse", 32'(vld_pulses - v0), 32'd1);

        // Test 5: async reset after the 4th data bit, then fresh 0x5A
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("t5_busy_pre", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_q", 32'(bus.q), 32'h0);
        check("t5_rst_valid", 32'(bus.valid), 32'd0);
        check("t5_rst_ferr", 32'(bus.frame_err), 32'd0);
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1);
        send_frame(8'h5A, 1'b1, 1'b0, "t5", c1);
        check("t5_valid", 32'(bus.valid), 32'd1);
        check("t5_q", 32'(bus.q), 32'h5A);
        check("t5_ferr", 32'(bus.frame_err), 32'd0);

        // Test 6: idle line for 50 cycles after reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        v0 = vld_pulses;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b1);
            check("t6_busy", 32'(bus.busy), 32'd0);
            check("t6_ferr", 32'(bus.frame_err), 32'd0);
            check("t6_q", 32'(bus.q), 32'h0);
        end
        check("t6_no_valid", 32'(vld_pulses - v0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
